fetch_unit: RTL and testbench

//  Owns the program counter and fetches instructions over a req/ack instruction-memory port.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/pc_next_mux.sv | 25 ++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state
// encoding, the canonical nop and the default boot address.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : riscv_pkg

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential PC+4, jal/branch target, or jalr target
// with bit 0 cleared. Flags any selected target that is not word aligned.
module pc_next_mux (
  input  logic [31:0] pc_i,
  input  logic        pc_src_i,
  input  logic        pc_target_src_i,
  input  logic [31:0] pc_target_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] pc_next_o,
  output logic        misalign_o
);

  // Select the next PC from the retiring instruction's redirect controls.
  always_comb begin
    // NOTE: default first so every path assigns pc_next_o; a missing branch would infer a latch.
    pc_next_o = pc_i + 32'd4;
    if (pc_src_i) begin
      pc_next_o = pc_target_src_i ? (alu_result_i & ~32'h1) : pc_target_i;
    end
  end

  // Bit 0 of a jalr target is already cleared, so only bit 1 can trip it there.
  assign misalign_o = (pc_next_o[1:0] != 2'b00);

endmodule : pc_next_mux

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word at a time over a
// req/ack port, holds it until the core retires it, then follows the
// controller's redirect. Misaligned redirects and fetch timeouts halt
// the unit with a sticky flag until reset.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic        PCTargetSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        instr_ready,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misalign,
  output logic        bus_err
);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic             instr_valid_q;
  logic             imem_req_q;
  logic             misalign_q;
  logic             bus_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      pc_next;
  logic             pc_next_misalign;

  pc_next_mux u_pc_next_mux (
    .pc_i            (pc_q),
    .pc_src_i        (PCSrc),
    .pc_target_src_i (PCTargetSrc),
    .pc_target_i     (PCTarget),
    .alu_result_i    (ALUResult),
    .pc_next_o       (pc_next),
    .misalign_o      (pc_next_misalign)
  );

  // Fetch FSM with PC, instruction latch, wait counter and registered outputs.
  // The outputs are set on the transition into each state, so they are glitch-free
  // and line up with the state register.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the edge-triggered block rather than in the sensitivity list.
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_REQ;
          imem_req_q <= 1'b1;
          cnt_q      <= '0;
        end

        ST_REQ: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            cnt_q         <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ST_HOLD;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            bus_err_q  <= 1'b1;
            imem_req_q <= 1'b0;
            state_q    <= ST_HALT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (pc_next_misalign) begin
              misalign_q <= 1'b1;
              state_q    <= ST_HALT;
            end else begin
              pc_q       <= pc_next;
              cnt_q      <= '0;
              imem_req_q <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
        end

        ST_HALT: begin
          state_q <= ST_HALT;
        end

        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed-plus-random bench for fetch_unit. A small reference model
// (expected PC and held instruction, next-PC rules as plain arithmetic)
// supplies every expected value.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic        PCTargetSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        instr_ready;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .PCTargetSrc (PCTargetSrc),
    .PCTarget    (PCTarget),
    .ALUResult   (ALUResult),
    .instr_ready (instr_ready),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Next PC from the redirect rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic src,
                                           input logic tsrc, input logic [31:0] tgt,
                                           input logic [31:0] alu);
    if (!src) return pc + 32'd4;
    if (!tsrc) return tgt;
    return alu & 32'hFFFF_FFFE;
  endfunction

  // Drive junk on the redirect inputs; they must be ignored outside a retire.
  task automatic junk_redirect();
    PCSrc       = 1'($urandom);
    PCTargetSrc = 1'($urandom);
    PCTarget    = $urandom;
    ALUResult   = $urandom;
  endtask

  // One reset edge, check reset state and the BOOT cycle, then the first request.
  task automatic do_reset();
    reset       = 1'b0;
    instr_ready = 1'b0;
    tick();
    m_pc    = RST_PC;
    m_instr = NOP_INSTR;
    imem_ack = 1'b0;
    reset    = 1'b1;
    check("rst_pc",       PC,          m_pc);
    check("rst_instr",    Instr,       NOP_INSTR);
    check("rst_valid",    instr_valid, 32'd0);
    check("rst_misalign", misalign,    32'd0);
    check("rst_bus_err",  bus_err,     32'd0);
    check("boot_req",     imem_req,    32'd0);
    tick();
    check("first_req",  imem_req,  32'd1);
    check("first_addr", imem_addr, m_pc);
  endtask

  // Serve the outstanding request after 'delay' idle REQ cycles.
  task automatic fetch(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      junk_redirect();
      tick();
      check("wait_req",   imem_req,    32'd1);
      check("wait_valid", instr_valid, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = data;
    check("f_valid", instr_valid, 32'd1);
    check("f_instr", Instr,       m_instr);
    check("f_pc",    PC,          m_pc);
    check("f_pc4",   PCPlus4,     m_pc + 32'd4);
    check("f_req",   imem_req,    32'd0);
  endtask

  // Stall the held instruction for n cycles; ack noise must be ignored.
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'($urandom);
      imem_rdata  = $urandom;
      junk_redirect();
      tick();
      check("st_instr", Instr,       m_instr);
      check("st_pc",    PC,          m_pc);
      check("st_req",   imem_req,    32'd0);
      check("st_valid", instr_valid, 32'd1);
    end
    imem_ack = 1'b0;
  endtask

  // Retire the held instruction with the given redirect controls.
  task automatic retire(input logic src, input logic tsrc, input logic [31:0] tgt,
                        input logic [31:0] alu);
    logic [31:0] nxt;
    nxt         = ref_next(m_pc, src, tsrc, tgt, alu);
    instr_ready = 1'b1;
    PCSrc       = src;
    PCTargetSrc = tsrc;
    PCTarget    = tgt;
    ALUResult   = alu;
    tick();
    instr_ready = 1'b0;
    junk_redirect();
    if (nxt[1:0] != 2'b00) begin
      check("r_misalign", misalign,    32'd1);
      check("r_halt_pc",  PC,          m_pc);
      check("r_halt_req", imem_req,    32'd0);
      check("r_halt_vld", instr_valid, 32'd0);
    end else begin
      m_pc = nxt;
      check("r_req",      imem_req,    32'd1);
      check("r_addr",     imem_addr,   m_pc);
      check("r_valid",    instr_valid, 32'd0);
      check("r_misalign", misalign,    32'd0);
    end
  endtask

  initial begin
    reset       = 1'b0;
    instr_ready = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    PCSrc       = 1'b0;
    PCTargetSrc = 1'b0;
    PCTarget    = '0;
    ALUResult   = '0;

    // 1. Reset, then first fetch acked two cycles after the request.
    do_reset();
    fetch(2, 32'h0050_0093);

    // 2. Stall three cycles, then sequential retire.
    stall(3);
    retire(1'b0, 1'b0, 32'h0, 32'h0);
    fetch(0, $urandom);

    // 3. Branch to 0x10, then to 0x40, then jalr to 0x81 -> 0x80.
    retire(1'b1, 1'b0, 32'h10, 32'h0);
    fetch(1, $urandom);
    retire(1'b1, 1'b0, 32'h40, 32'h0);
    check("t3_addr40", imem_addr, 32'h40);
    fetch(0, $urandom);
    retire(1'b1, 1'b1, 32'h0, 32'h81);
    check("t3_addr80", imem_addr, 32'h80);
    fetch(3, $urandom);

    // PC wrap at the top of the address space.
    retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch(0, $urandom);
    retire(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    fetch(1, $urandom);

    // Random aligned traffic.
    for (int k = 0; k < 20; k++) begin
      logic        src;
      logic        tsrc;
      src  = 1'($urandom);
      tsrc = 1'($urandom);
      stall(int'($urandom_range(0, 2)));
      retire(src, tsrc, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD);
      fetch(int'($urandom_range(0, 6)), $urandom);
    end

    // 4. Misaligned branch target halts; only reset recovers.
    retire(1'b1, 1'b0, 32'h42, 32'h0);
    for (int i = 0; i < 3; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      instr_ready = 1'b1;
      tick();
      check("halt_req",  imem_req, 32'd0);
      check("halt_mis",  misalign, 32'd1);
      check("halt_pc",   PC,       m_pc);
    end
    imem_ack = 1'b0;
    do_reset();
    fetch(0, $urandom);

    // 5. Timeout: request cycle 16 still waiting, bus_err the cycle after.
    do_reset();
    for (int i = 1; i < TMO; i++) tick();
    check("to_16th_req", imem_req, 32'd1);
    check("to_16th_err", bus_err,  32'd0);
    tick();
    check("to_bus_err", bus_err,  32'd1);
    check("to_req_low", imem_req, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("late_valid", instr_valid, 32'd0);
    check("late_instr", Instr,       NOP_INSTR);
    check("late_err",   bus_err,     32'd1);

    // 6. Reset during a request with ack asserted aborts the request.
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    do_reset();
    fetch(1, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
